// File: rtl/cp0_except_ctrl.sv
// Purpose: exception initiator at the MEM/WB boundary. It forwards in-flight WB writes to CP0
//          Status/Cause/EPC, arbitrates interrupts against synchronous exceptions, and drives the
//          CP0 excepttype/inst-addr/delay-slot inputs, the pipeline flush and the redirect PC.
// Latency: an exception detected in cycle N shows on the registered outputs in cycle N+1.
// Backpressure: none. While the flush is active (busy_o=1), MEM exception flags and interrupts
//          are dropped, not queued.
// Ports:
//   clk, rst (async, active-low)
//   mem_*_i           MEM-stage valid, exception flags {eret,ov,trap,inv,syscall}, PC, delay slot
//   cp0_*_i           live Status/Cause/EPC from CP0
//   wb_cp0_*_i        WB-stage CP0 write (we/addr/data) used for forwarding
//   excepttype_o      one-cycle exception code pulse to CP0
//   cur_inst_addr_o   PC of the excepting instruction
//   in_delayslot_o    delay-slot flag of the excepting instruction
//   flush_o           pipeline flush, held for FLUSH_CYCLES cycles
//   new_pc_o          redirect target, valid while flush_o=1
//   busy_o            flush sequence in progress
module cp0_except_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [4:0]  mem_except_i,
    input  logic [31:0] mem_inst_addr_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cur_inst_addr_o,
    output logic        in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    localparam logic [31:0] CODE_NONE    = 32'h0000_0000;
    localparam logic [31:0] CODE_INT     = 32'h0000_0001;
    localparam logic [31:0] CODE_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] CODE_INV     = 32'h0000_000a;
    localparam logic [31:0] CODE_TRAP    = 32'h0000_000d;
    localparam logic [31:0] CODE_OV      = 32'h0000_000c;
    localparam logic [31:0] CODE_ERET    = 32'h0000_000e;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] exctype_q, exctype_d;
    logic [31:0] addr_q, addr_d;
    logic        ds_q, ds_d;
    logic        flush_q, flush_d;
    logic [31:0] newpc_q, newpc_d;

    // Forwarding of a WB-stage CP0 write so this cycle's arbitration sees it
    logic [31:0] eff_status, eff_cause, eff_epc;
    logic        irq_pend;
    logic        arb_en;
    logic [31:0] code;

    always_comb begin
        eff_status = cp0_status_i;
        eff_cause  = cp0_cause_i;
        eff_epc    = cp0_epc_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_STATUS) eff_status = wb_cp0_data_i;
        // Only the software interrupt bits IP[1:0] are writable in Cause
        if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_CAUSE)  eff_cause[9:8] = wb_cp0_data_i[9:8];
        if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_EPC)    eff_epc = wb_cp0_data_i;
    end

    // IE set, EXL clear, and an unmasked pending line
    assign irq_pend = eff_status[0] & ~eff_status[1]
                    & (|(eff_cause[15:8] & eff_status[15:8]));

    // Bubbles and PC 0 (flushed slots) never raise exceptions
    assign arb_en = (state_q == IDLE) && mem_valid_i && (mem_inst_addr_i != 32'h0);

    always_comb begin
        code = CODE_NONE;
        if (arb_en) begin
            if      (irq_pend)        code = CODE_INT;
            else if (mem_except_i[0]) code = CODE_SYSCALL;
            else if (mem_except_i[1]) code = CODE_INV;
            else if (mem_except_i[2]) code = CODE_TRAP;
            else if (mem_except_i[3]) code = CODE_OV;
            else if (mem_except_i[4]) code = CODE_ERET;
        end
    end

    // State register (also holds the registered outputs)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            exctype_q <= 32'h0;
            addr_q    <= 32'h0;
            ds_q      <= 1'b0;
            flush_q   <= 1'b0;
            newpc_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exctype_q <= exctype_d;
            addr_q    <= addr_d;
            ds_q      <= ds_d;
            flush_q   <= flush_d;
            newpc_q   <= newpc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (code != CODE_NONE) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_INIT;
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: excepttype defaults to 0 so it pulses for exactly one cycle
    always_comb begin
        exctype_d = CODE_NONE;
        addr_d    = addr_q;
        ds_d      = ds_q;
        flush_d   = flush_q;
        newpc_d   = newpc_q;
        if (state_q == IDLE && code != CODE_NONE) begin
            exctype_d = code;
            addr_d    = mem_inst_addr_i;
            ds_d      = mem_in_delayslot_i;
            flush_d   = 1'b1;
            newpc_d   = (code == CODE_ERET) ? eff_epc : EXC_VECTOR;
        end else if (state_q == FLUSH && cnt_q == 4'd0) begin
            flush_d   = 1'b0;
        end
    end

    assign excepttype_o    = exctype_q;
    assign cur_inst_addr_o = addr_q;
    assign in_delayslot_o  = ds_q;
    assign flush_o         = flush_q;
    assign new_pc_o        = newpc_q;
    assign busy_o          = (state_q == FLUSH);

    // Status/Cause fields that play no part in interrupt arbitration
    logic unused_bits;
    assign unused_bits = ^{eff_status[31:16], eff_status[7:2], eff_cause[31:16], eff_cause[7:0]};

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Purpose: directed self-checking bench for cp0_except_ctrl.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: not applicable.
module tb_cp0_except_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_valid_i;
    logic [4:0]  mem_except_i;
    logic [31:0] mem_inst_addr_i;
    logic        mem_in_delayslot_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o;
    logic [31:0] cur_inst_addr_o;
    logic        in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    cp0_except_ctrl #(
        .EXC_VECTOR  (32'h0000_0020),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_valid_i       (mem_valid_i),
        .mem_except_i      (mem_except_i),
        .mem_inst_addr_i   (mem_inst_addr_i),
        .mem_in_delayslot_i(mem_in_delayslot_i),
        .cp0_status_i      (cp0_status_i),
        .cp0_cause_i       (cp0_cause_i),
        .cp0_epc_i         (cp0_epc_i),
        .wb_cp0_we_i       (wb_cp0_we_i),
        .wb_cp0_waddr_i    (wb_cp0_waddr_i),
        .wb_cp0_data_i     (wb_cp0_data_i),
        .excepttype_o      (excepttype_o),
        .cur_inst_addr_o   (cur_inst_addr_o),
        .in_delayslot_o    (in_delayslot_o),
        .flush_o           (flush_o),
        .new_pc_o          (new_pc_o),
        .busy_o            (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        mem_valid_i        = 1'b0;
        mem_except_i       = 5'b0;
        mem_inst_addr_i    = 32'h0;
        mem_in_delayslot_i = 1'b0;
        cp0_status_i       = 32'h0;
        cp0_cause_i        = 32'h0;
        cp0_epc_i          = 32'h0;
        wb_cp0_we_i        = 1'b0;
        wb_cp0_waddr_i     = 5'd0;
        wb_cp0_data_i      = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction in MEM this cycle (status/cause/wb set by caller beforehand)
    task automatic present(input logic [4:0] ex, input logic [31:0] addr, input logic ds);
        mem_valid_i        = 1'b1;
        mem_except_i       = ex;
        mem_inst_addr_i    = addr;
        mem_in_delayslot_i = ds;
    endtask

    // Clear inputs and let a 2-cycle flush run out; checks it has fallen
    task automatic drain(input string tag);
        @(negedge clk);
        clear_inputs();
        step();
        chk({tag, "_flush_hold"}, {31'b0, flush_o}, 32'h1);
        step();
        chk({tag, "_flush_fall"}, {31'b0, flush_o}, 32'h0);
        chk({tag, "_busy_fall"},  {31'b0, busy_o},  32'h0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        #3;
        chk("rst_exctype", excepttype_o, 32'h0);
        chk("rst_flush",   {31'b0, flush_o}, 32'h0);
        chk("rst_busy",    {31'b0, busy_o},  32'h0);
        chk("rst_newpc",   new_pc_o, 32'h0);
        chk("rst_addr",    cur_inst_addr_o, 32'h0);
        chk("rst_ds",      {31'b0, in_delayslot_o}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("idle_exctype", excepttype_o, 32'h0);

        // Syscall
        @(negedge clk);
        present(5'b00001, 32'h0000_0100, 1'b0);
        step();
        chk("sys_code",  excepttype_o, 32'h8);
        chk("sys_addr",  cur_inst_addr_o, 32'h100);
        chk("sys_newpc", new_pc_o, 32'h20);
        chk("sys_flush", {31'b0, flush_o}, 32'h1);
        chk("sys_busy",  {31'b0, busy_o},  32'h1);
        @(negedge clk);
        clear_inputs();
        step();
        chk("sys_code_pulse", excepttype_o, 32'h0);
        chk("sys_flush2",     {31'b0, flush_o}, 32'h1);
        chk("sys_newpc_hold", new_pc_o, 32'h20);
        step();
        chk("sys_flush_fall", {31'b0, flush_o}, 32'h0);
        chk("sys_addr_hold",  cur_inst_addr_o, 32'h100);

        // Interrupt beats syscall; delay slot captured
        @(negedge clk);
        cp0_status_i = 32'h0000_0401;
        cp0_cause_i  = 32'h0000_0400;
        present(5'b00001, 32'h0000_0104, 1'b1);
        step();
        chk("irq_code", excepttype_o, 32'h1);
        chk("irq_ds",   {31'b0, in_delayslot_o}, 32'h1);
        chk("irq_addr", cur_inst_addr_o, 32'h104);
        drain("irq");

        // Status forwarded from WB
        @(negedge clk);
        cp0_cause_i    = 32'h0000_0400;
        wb_cp0_we_i    = 1'b1;
        wb_cp0_waddr_i = 5'd12;
        wb_cp0_data_i  = 32'h0000_0401;
        present(5'b00000, 32'h0000_0108, 1'b0);
        step();
        chk("fwd_status_code", excepttype_o, 32'h1);
        drain("fwd_status");

        // Cause IP bits forwarded from WB
        @(negedge clk);
        cp0_status_i   = 32'h0000_0101;
        wb_cp0_we_i    = 1'b1;
        wb_cp0_waddr_i = 5'd13;
        wb_cp0_data_i  = 32'h0000_0100;
        present(5'b00000, 32'h0000_010c, 1'b0);
        step();
        chk("fwd_cause_code", excepttype_o, 32'h1);
        drain("fwd_cause");

        // Only Cause[9:8] forwards: a WB write of Cause[10] must not raise an interrupt
        @(negedge clk);
        cp0_status_i   = 32'h0000_0401;
        wb_cp0_we_i    = 1'b1;
        wb_cp0_waddr_i = 5'd13;
        wb_cp0_data_i  = 32'h0000_0400;
        present(5'b00000, 32'h0000_0110, 1'b0);
        step();
        chk("fwd_cause_hw_code", excepttype_o, 32'h0);

        // EPC forwarded for ERET
        @(negedge clk);
        clear_inputs();
        cp0_epc_i      = 32'h0000_0300;
        wb_cp0_we_i    = 1'b1;
        wb_cp0_waddr_i = 5'd14;
        wb_cp0_data_i  = 32'h0000_0200;
        present(5'b10000, 32'h0000_0114, 1'b0);
        step();
        chk("eret_fwd_code",  excepttype_o, 32'he);
        chk("eret_fwd_newpc", new_pc_o, 32'h200);
        drain("eret_fwd");

        // ERET with no forwarding uses live EPC
        @(negedge clk);
        cp0_epc_i = 32'h0000_0300;
        present(5'b10000, 32'h0000_0118, 1'b0);
        step();
        chk("eret_live_newpc", new_pc_o, 32'h300);
        drain("eret_live");

        // Priority among synchronous flags
        @(negedge clk);
        present(5'b00110, 32'h0000_0120, 1'b0);
        step();
        chk("prio_inv_trap", excepttype_o, 32'ha);
        drain("prio_a");
        @(negedge clk);
        present(5'b11100, 32'h0000_0124, 1'b0);
        step();
        chk("prio_trap_ov", excepttype_o, 32'hd);
        drain("prio_b");
        @(negedge clk);
        present(5'b11000, 32'h0000_0128, 1'b0);
        step();
        chk("prio_ov_eret", excepttype_o, 32'hc);
        drain("prio_c");

        // Masking: EXL set, address 0, bubble
        @(negedge clk);
        cp0_status_i = 32'h0000_0403;
        cp0_cause_i  = 32'h0000_0400;
        present(5'b00000, 32'h0000_0130, 1'b0);
        step();
        chk("mask_exl_code",  excepttype_o, 32'h0);
        chk("mask_exl_flush", {31'b0, flush_o}, 32'h0);
        @(negedge clk);
        clear_inputs();
        present(5'b01000, 32'h0000_0000, 1'b0);
        step();
        chk("mask_addr0_code", excepttype_o, 32'h0);
        @(negedge clk);
        present(5'b01000, 32'h0000_0134, 1'b0);
        mem_valid_i = 1'b0;
        step();
        chk("mask_bubble_code", excepttype_o, 32'h0);
        chk("mask_bubble_busy", {31'b0, busy_o}, 32'h0);

        // Flush blocking: ov at N, trap held from N+1
        @(negedge clk);
        present(5'b01000, 32'h0000_0180, 1'b0);
        step();
        chk("blk_ov_code", excepttype_o, 32'hc);
        @(negedge clk);
        present(5'b00100, 32'h0000_0184, 1'b0);
        step();
        chk("blk_n2_code",  excepttype_o, 32'h0);
        chk("blk_n2_flush", {31'b0, flush_o}, 32'h1);
        step();
        chk("blk_n3_code",  excepttype_o, 32'h0);
        chk("blk_n3_flush", {31'b0, flush_o}, 32'h0);
        step();
        chk("blk_trap_code", excepttype_o, 32'hd);
        chk("blk_trap_addr", cur_inst_addr_o, 32'h184);

        // Async reset mid-flush, between clock edges
        @(negedge clk);
        clear_inputs();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_flush",   {31'b0, flush_o}, 32'h0);
        chk("arst_busy",    {31'b0, busy_o},  32'h0);
        chk("arst_exctype", excepttype_o, 32'h0);
        chk("arst_newpc",   new_pc_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("arst_after_busy", {31'b0, busy_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
